// File: rtl/mnc_pkg.sv
// Shared types and constants for the mnc_sweep_ctrl gate-circuit self-test sequencer.
package mnc_pkg;

    localparam int unsigned MNC_CODE_W    = 4;
    localparam int unsigned MNC_NUM_CODES = 16;
    localparam int unsigned MNC_ERR_W     = 5;
    localparam int unsigned MNC_SETTLE_W  = 4;
    localparam logic [31:0] MNC_GOLDEN_DEFAULT = 32'hEEEE_77EC;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } mnc_state_t;

endpackage

// File: rtl/mnc_sweep_ctrl_if.sv
// Control, stimulus and result signals between the sweep sequencer and its user/circuit.
interface mnc_sweep_ctrl_if;
    import mnc_pkg::*;

    logic                  start;
    logic                  abort;
    logic                  f1;
    logic                  f2;
    logic [MNC_CODE_W-1:0] abcd;
    logic                  busy;
    logic                  done;
    logic                  pass;
    logic [MNC_ERR_W-1:0]  err_count;
    logic                  fail_valid;
    logic [MNC_CODE_W-1:0] first_fail;

    modport master (
        output start, abort, f1, f2,
        input  abcd, busy, done, pass, err_count, fail_valid, first_fail
    );

    modport slave (
        input  start, abort, f1, f2,
        output abcd, busy, done, pass, err_count, fail_valid, first_fail
    );

endinterface

// File: rtl/mnc_golden_lut.sv
// Combinational lookup of the expected {F1,F2} pair for one input code.
module mnc_golden_lut
    import mnc_pkg::*;
#(
    parameter logic [31:0] GOLDEN = MNC_GOLDEN_DEFAULT
) (
    input  logic [MNC_CODE_W-1:0] code,
    output logic [1:0]            exp_c
);

    assign exp_c = GOLDEN[{code, 1'b0} +: 2];

endmodule

// File: rtl/mnc_sweep_ctrl.sv
// Self-test sequencer: sweeps all 16 ABCD codes, compares F1/F2 against a golden table.
// Optional build macro MNC_STOP_ON_FAIL_EN ends the sweep at the first mismatch.
module mnc_sweep_ctrl
    import mnc_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter logic [31:0] GOLDEN        = MNC_GOLDEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    mnc_sweep_ctrl_if.slave bus
);

    localparam logic [MNC_SETTLE_W-1:0] SETTLE_LOAD = MNC_SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [MNC_CODE_W-1:0]   PRE_LAST    = MNC_CODE_W'(MNC_NUM_CODES - 2);

    mnc_state_t               state_q, state_d;
    logic [MNC_CODE_W-1:0]    code_q, code_d;
    logic                     last_q, last_d;
    logic [MNC_SETTLE_W-1:0]  settle_q, settle_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     pass_q, pass_d;
    logic [MNC_ERR_W-1:0]     err_q, err_d;
    logic                     fv_q, fv_d;
    logic [MNC_CODE_W-1:0]    ff_q, ff_d;
    logic [1:0]               exp_c;
    logic                     mismatch_c;
    logic                     stop_c;

    mnc_golden_lut #(.GOLDEN(GOLDEN)) u_lut (
        .code  (code_q),
        .exp_c (exp_c)
    );

    assign mismatch_c = ({bus.f1, bus.f2} != exp_c);

    // Next-state, counter and result update
    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        last_d   = last_q;
        settle_d = settle_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        pass_d   = pass_q;
        err_d    = err_q;
        fv_d     = fv_q;
        ff_d     = ff_q;
        stop_c   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    err_d    = '0;
                    fv_d     = 1'b0;
                    ff_d     = '0;
                    pass_d   = 1'b0;
                    code_d   = '0;
                    last_d   = 1'b0;
                    settle_d = SETTLE_LOAD;
                    busy_d   = 1'b1;
                    state_d  = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    code_d  = '0;
                end else if (settle_q == '0) begin
                    state_d = ST_SAMPLE;
                end else begin
                    settle_d = settle_q - 1'b1;
                end
            end
            ST_SAMPLE: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    code_d  = '0;
                end else begin
                    if (mismatch_c) begin
                        err_d = err_q + 1'b1;
                        if (!fv_q) begin
                            fv_d = 1'b1;
                            ff_d = code_q;
                        end
                    end
`ifdef MNC_STOP_ON_FAIL_EN
                    stop_c = last_q | mismatch_c;
`else
                    stop_c = last_q;
`endif
                    if (stop_c) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        pass_d  = (err_d == '0);
                        code_d  = '0;
                    end else begin
                        code_d   = code_q + 1'b1;
                        last_d   = (code_q == PRE_LAST);
                        settle_d = SETTLE_LOAD;
                        state_d  = ST_DRIVE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                code_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            code_q   <= '0;
            last_q   <= 1'b0;
            settle_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            err_q    <= '0;
            fv_q     <= 1'b0;
            ff_q     <= '0;
        end else begin
            state_q  <= state_d;
            code_q   <= code_d;
            last_q   <= last_d;
            settle_q <= settle_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            err_q    <= err_d;
            fv_q     <= fv_d;
            ff_q     <= ff_d;
        end
    end

    assign bus.abcd       = code_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.pass       = pass_q;
    assign bus.err_count  = err_q;
    assign bus.fail_valid = fv_q;
    assign bus.first_fail = ff_q;

endmodule

// File: tb/tb_mnc_sweep_ctrl.sv
// Scoreboard bench for mnc_sweep_ctrl: a faultable model of the gate circuit feeds f1/f2.
module tb_mnc_sweep_ctrl;
    import mnc_pkg::*;

    localparam int unsigned SETTLE   = 2;
    localparam int unsigned MAX_WAIT = 200;

    typedef struct {
        int err;
        int ff;
        int fv;
        int pass;
        int lat;
    } exp_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] ref_golden = 32'hEEEE_77EC;
    int          fault_mode = 0;
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail  = 0;
    exp_t        sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mnc_sweep_ctrl_if bus_if ();

    mnc_sweep_ctrl #(
        .SETTLE_CYCLES (SETTLE),
        .GOLDEN        (32'hEEEE_77EC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    // Gate circuit under test, with injectable faults
    assign bus_if.f1 = ref_golden[{bus_if.abcd, 1'b1}] ^ (fault_mode == 1 && bus_if.abcd == 4'd4);
    assign bus_if.f2 = (fault_mode == 2) ? 1'b0 : ref_golden[{bus_if.abcd, 1'b0}];

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input int mode);
        exp_t e;
        int   last;
        bit   g1, g2, a1, a2;
        e.err = 0; e.ff = 0; e.fv = 0;
        last = 15;
        for (int i = 0; i < 16; i++) begin
            g1 = ref_golden[2*i+1];
            g2 = ref_golden[2*i];
            a1 = g1 ^ (mode == 1 && i == 4);
            a2 = (mode == 2) ? 1'b0 : g2;
            if ({a1, a2} != {g1, g2}) begin
                e.err++;
                if (e.fv == 0) begin
                    e.fv = 1;
                    e.ff = i;
                end
`ifdef MNC_STOP_ON_FAIL_EN
                last = i;
                break;
`endif
            end
        end
        e.pass = (e.err == 0) ? 1 : 0;
        e.lat  = (last + 1) * int'(SETTLE + 1);
        return e;
    endfunction

    task automatic check_all_zero(input string pfx);
        chk({pfx, "_abcd"},  int'(bus_if.abcd), 0);
        chk({pfx, "_busy"},  int'(bus_if.busy), 0);
        chk({pfx, "_done"},  int'(bus_if.done), 0);
        chk({pfx, "_pass"},  int'(bus_if.pass), 0);
        chk({pfx, "_err"},   int'(bus_if.err_count), 0);
        chk({pfx, "_fv"},    int'(bus_if.fail_valid), 0);
        chk({pfx, "_ff"},    int'(bus_if.first_fail), 0);
    endtask

    task automatic pulse_start(output int t0);
        @(negedge clk);
        bus_if.start = 1'b1;
        t0 = cyc + 1;
        @(negedge clk);
        bus_if.start = 1'b0;
        chk("start_busy", int'(bus_if.busy), 1);
        chk("start_abcd", int'(bus_if.abcd), 0);
    endtask

    task automatic wait_code(input int code, output bit hit);
        hit = 1'b0;
        for (int n = 0; n < int'(MAX_WAIT); n++) begin
            if (int'(bus_if.abcd) == code) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk($sformatf("reach_code%0d", code), int'(hit), 1);
    endtask

    task automatic run_sweep(input int mode, input bit repulse);
        exp_t e;
        int   t0;
        bit   seen, pulsed;
        fault_mode = mode;
        sb.push_back(model(mode));
        pulse_start(t0);
        seen = 1'b0;
        pulsed = 1'b0;
        for (int n = 0; n < int'(MAX_WAIT); n++) begin
            if (bus_if.done) begin
                seen = 1'b1;
                break;
            end
            if (repulse && !pulsed && bus_if.abcd == 4'd3) begin
                bus_if.start = 1'b1;
                pulsed = 1'b1;
            end else begin
                bus_if.start = 1'b0;
            end
            @(negedge clk);
        end
        bus_if.start = 1'b0;
        e = sb.pop_front();
        chk("done_seen", int'(seen), 1);
        if (seen) begin
            chk("latency",    cyc - t0, e.lat);
            chk("err_count",  int'(bus_if.err_count), e.err);
            chk("fail_valid", int'(bus_if.fail_valid), e.fv);
            chk("first_fail", int'(bus_if.first_fail), e.ff);
            chk("pass",       int'(bus_if.pass), e.pass);
            chk("busy_at_done", int'(bus_if.busy), 0);
            @(negedge clk);
            chk("done_pulse_len", int'(bus_if.done), 0);
        end
    endtask

    initial begin
        int t0;
        int done_cnt;
        bit hit;
        bus_if.start = 1'b0;
        bus_if.abort = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_sweep(0, 1'b0);
        run_sweep(1, 1'b0);
        run_sweep(2, 1'b0);

        // Abort while code 7 is driven
        fault_mode = 0;
        pulse_start(t0);
        wait_code(7, hit);
        bus_if.abort = 1'b1;
        @(negedge clk);
        bus_if.abort = 1'b0;
        chk("abort_busy", int'(bus_if.busy), 0);
        chk("abort_abcd", int'(bus_if.abcd), 0);
        done_cnt = 0;
        for (int n = 0; n < 60; n++) begin
            if (bus_if.done) done_cnt++;
            @(negedge clk);
        end
        chk("abort_no_done", done_cnt, 0);
        chk("abort_pass", int'(bus_if.pass), 0);
        run_sweep(0, 1'b0);

        // start re-pulsed mid-sweep must not disturb timing
        run_sweep(0, 1'b1);

        // Asynchronous reset at code 10
        run_sweep(1, 1'b0);
        pulse_start(t0);
        wait_code(10, hit);
        #2 rst_n = 1'b0;
        #1 check_all_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_rst_busy", int'(bus_if.busy), 0);

        run_sweep(0, 1'b0);
        chk("sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
